// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: widths, LSB access types,
// arbiter states and the downstream command payload.
package mem_arbiter_pkg;

   localparam int unsigned LSB_TYPE_WIDTH = 3;
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned DATA_W         = 32;
   localparam int unsigned MC_LEN_W       = 3;

   localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 32'h0003_0000;

   typedef enum logic [LSB_TYPE_WIDTH-1:0] {
      LSB_LB  = 3'd0,
      LSB_LH  = 3'd1,
      LSB_LW  = 3'd2,
      LSB_LBU = 3'd3,
      LSB_LHU = 3'd4,
      LSB_SB  = 3'd5,
      LSB_SH  = 3'd6,
      LSB_SW  = 3'd7
   } lsb_type_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_BUSY_IF  = 3'd1,
      ST_BUSY_LSB = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_IO_WAIT  = 3'd4
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic                wr;
      logic [MC_LEN_W-1:0] len;
      logic [DATA_W-1:0]   wdata;
   } mc_cmd_t;

endpackage

// File: rtl/mem_arbiter_lsb_extend.sv
// Load/store type decode: access length, write flag, and extension of the
// zero-extended controller read data into the architectural load result.
module lsb_extend
   import mem_arbiter_pkg::*;
(
   input  logic [LSB_TYPE_WIDTH-1:0] lsb_type,
   input  logic [DATA_W-1:0]         mc_rdata,
   output logic [MC_LEN_W-1:0]       len_c,
   output logic                      wr_c,
   output logic [DATA_W-1:0]         rdata_c
);

   lsb_type_e type_c;

   assign type_c = lsb_type_e'(lsb_type);

   always_comb begin
      len_c   = MC_LEN_W'(4);
      wr_c    = 1'b0;
      rdata_c = mc_rdata;
      case (type_c)
         LSB_LB: begin
            len_c   = MC_LEN_W'(1);
            rdata_c = {{24{mc_rdata[7]}}, mc_rdata[7:0]};
         end
         LSB_LBU: begin
            len_c   = MC_LEN_W'(1);
            rdata_c = {24'h0, mc_rdata[7:0]};
         end
         LSB_LH: begin
            len_c   = MC_LEN_W'(2);
            rdata_c = {{16{mc_rdata[15]}}, mc_rdata[15:0]};
         end
         LSB_LHU: begin
            len_c   = MC_LEN_W'(2);
            rdata_c = {16'h0, mc_rdata[15:0]};
         end
         LSB_LW: begin
            len_c   = MC_LEN_W'(4);
         end
         // Stores return no data to the LSB.
         LSB_SB: begin
            len_c   = MC_LEN_W'(1);
            wr_c    = 1'b1;
            rdata_c = '0;
         end
         LSB_SH: begin
            len_c   = MC_LEN_W'(2);
            wr_c    = 1'b1;
            rdata_c = '0;
         end
         LSB_SW: begin
            len_c   = MC_LEN_W'(4);
            wr_c    = 1'b1;
            rdata_c = '0;
         end
         default: begin
            len_c   = MC_LEN_W'(4);
            wr_c    = 1'b0;
            rdata_c = mc_rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store requests onto a single
// byte-serial memory controller port, with fetch anti-starvation and IO backpressure.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned       STARVE_LIMIT = 2,
   parameter logic [ADDR_W-1:0] IO_BASE      = IO_BASE_DEFAULT
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      rdy_in,
   input  logic                      flush,
   input  logic                      io_buffer_full,

   input  logic                      if_en,
   input  logic [ADDR_W-1:0]         if_addr,
   output logic                      if_rdy,
   output logic [DATA_W-1:0]         if_data,

   input  logic                      lsb_en,
   input  logic [ADDR_W-1:0]         lsb_addr,
   input  logic [LSB_TYPE_WIDTH-1:0] lsb_type,
   input  logic [DATA_W-1:0]         lsb_wdata,
   output logic                      lsb_rdy,
   output logic [DATA_W-1:0]         lsb_rdata,

   output logic                      mc_req,
   output logic [ADDR_W-1:0]         mc_addr,
   output logic                      mc_wr,
   output logic [MC_LEN_W-1:0]       mc_len,
   output logic [DATA_W-1:0]         mc_wdata,
   input  logic                      mc_done,
   input  logic [DATA_W-1:0]         mc_rdata
);

   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_e           state_q, state_d;
   logic [CNT_W-1:0]     starve_q, starve_d;
   mc_cmd_t              cmd_q, cmd_d;
   logic                 mc_req_q, mc_req_d;
   logic                 if_rdy_q, if_rdy_d;
   logic [DATA_W-1:0]    if_data_q, if_data_d;
   logic                 lsb_rdy_q, lsb_rdy_d;
   logic [DATA_W-1:0]    lsb_rdata_q, lsb_rdata_d;

   logic [MC_LEN_W-1:0]  lsb_len_c;
   logic                 lsb_wr_c;
   logic [DATA_W-1:0]    lsb_ext_c;
   logic                 fetch_req_c;
   logic                 fetch_wins_c;
   logic                 io_block_c;
   logic                 idle_free_c;

   lsb_extend u_lsb_extend (
      .lsb_type (lsb_type),
      .mc_rdata (mc_rdata),
      .len_c    (lsb_len_c),
      .wr_c     (lsb_wr_c),
      .rdata_c  (lsb_ext_c)
   );

   // A flush in IDLE hides the fetch request for that cycle only.
   assign fetch_req_c  = if_en & ~flush;
   assign fetch_wins_c = fetch_req_c & (~lsb_en | (starve_q == STARVE_MAX));
   assign io_block_c   = lsb_wr_c & (lsb_addr >= IO_BASE) & io_buffer_full;
   // Requesters still hold en during their rdy pulse, so no grant that cycle.
   assign idle_free_c  = ~if_rdy_q & ~lsb_rdy_q;

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      cmd_d       = cmd_q;
      mc_req_d    = mc_req_q;
      if_rdy_d    = rdy_in ? 1'b0 : if_rdy_q;
      if_data_d   = if_data_q;
      lsb_rdy_d   = rdy_in ? 1'b0 : lsb_rdy_q;
      lsb_rdata_d = lsb_rdata_q;

      if (rdy_in) begin
         if (!if_en) begin
            starve_d = '0;
         end
         case (state_q)
            ST_IDLE: begin
               if (idle_free_c) begin
                  if (fetch_wins_c) begin
                     state_d     = ST_BUSY_IF;
                     starve_d    = '0;
                     mc_req_d    = 1'b1;
                     cmd_d.addr  = if_addr;
                     cmd_d.wr    = 1'b0;
                     cmd_d.len   = MC_LEN_W'(4);
                     cmd_d.wdata = '0;
                  end else if (lsb_en) begin
                     if (if_en && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + CNT_W'(1);
                     end
                     if (io_block_c) begin
                        state_d = ST_IO_WAIT;
                     end else begin
                        state_d     = ST_BUSY_LSB;
                        mc_req_d    = 1'b1;
                        cmd_d.addr  = lsb_addr;
                        cmd_d.wr    = lsb_wr_c;
                        cmd_d.len   = lsb_len_c;
                        cmd_d.wdata = lsb_wdata;
                     end
                  end
               end
            end
            ST_IO_WAIT: begin
               if (!io_buffer_full) begin
                  state_d     = ST_BUSY_LSB;
                  mc_req_d    = 1'b1;
                  cmd_d.addr  = lsb_addr;
                  cmd_d.wr    = lsb_wr_c;
                  cmd_d.len   = lsb_len_c;
                  cmd_d.wdata = lsb_wdata;
               end
            end
            ST_BUSY_IF: begin
               if (flush) begin
                  if (mc_done) begin
                     state_d  = ST_IDLE;
                     mc_req_d = 1'b0;
                  end else begin
                     state_d  = ST_DRAIN;
                  end
               end else if (mc_done) begin
                  state_d   = ST_IDLE;
                  mc_req_d  = 1'b0;
                  if_rdy_d  = 1'b1;
                  if_data_d = mc_rdata;
               end
            end
            ST_BUSY_LSB: begin
               if (mc_done) begin
                  state_d     = ST_IDLE;
                  mc_req_d    = 1'b0;
                  lsb_rdy_d   = 1'b1;
                  lsb_rdata_d = lsb_ext_c;
               end
            end
            // Flushed fetch: let the controller finish, then drop the data.
            ST_DRAIN: begin
               if (mc_done) begin
                  state_d  = ST_IDLE;
                  mc_req_d = 1'b0;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               mc_req_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= ST_IDLE;
         starve_q    <= '0;
         cmd_q       <= '0;
         mc_req_q    <= 1'b0;
         if_rdy_q    <= 1'b0;
         if_data_q   <= '0;
         lsb_rdy_q   <= 1'b0;
         lsb_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         cmd_q       <= cmd_d;
         mc_req_q    <= mc_req_d;
         if_rdy_q    <= if_rdy_d;
         if_data_q   <= if_data_d;
         lsb_rdy_q   <= lsb_rdy_d;
         lsb_rdata_q <= lsb_rdata_d;
      end
   end

   assign mc_req    = mc_req_q;
   assign mc_addr   = cmd_q.addr;
   assign mc_wr     = cmd_q.wr;
   assign mc_len    = cmd_q.len;
   assign mc_wdata  = cmd_q.wdata;
   assign if_rdy    = if_rdy_q;
   assign if_data   = if_data_q;
   assign lsb_rdy   = lsb_rdy_q;
   assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays the memory
// controller and both requesters, driving and sampling on the falling edge.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk, rst_n, rdy_in, flush, io_buffer_full;
   logic        if_en, if_rdy;
   logic [31:0] if_addr, if_data;
   logic        lsb_en, lsb_rdy;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
   logic [2:0]  lsb_type;
   logic        mc_req, mc_wr, mc_done;
   logic [31:0] mc_addr, mc_wdata, mc_rdata;
   logic [2:0]  mc_len;

   int checks = 0;
   int fails  = 0;

   mem_arbiter #(.STARVE_LIMIT(2), .IO_BASE(32'h0003_0000)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .flush(flush),
      .io_buffer_full(io_buffer_full),
      .if_en(if_en), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
      .lsb_en(lsb_en), .lsb_addr(lsb_addr), .lsb_type(lsb_type),
      .lsb_wdata(lsb_wdata), .lsb_rdy(lsb_rdy), .lsb_rdata(lsb_rdata),
      .mc_req(mc_req), .mc_addr(mc_addr), .mc_wr(mc_wr), .mc_len(mc_len),
      .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   // Controller model: wait (bounded) for mc_req, hold for lat cycles, pulse mc_done.
   task automatic mc_serve(input int lat, input logic [31:0] rdata,
                           output logic seen, output logic [31:0] addr_seen,
                           output logic [2:0] len_seen, output logic wr_seen);
      int n = 0;
      seen = 1'b0; addr_seen = '0; len_seen = '0; wr_seen = 1'b0;
      while (mc_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (mc_req === 1'b1) begin
         seen = 1'b1; addr_seen = mc_addr; len_seen = mc_len; wr_seen = mc_wr;
         repeat (lat) @(negedge clk);
         mc_done = 1'b1; mc_rdata = rdata;
         @(negedge clk);
         mc_done = 1'b0; mc_rdata = '0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      if_en = 1'b0; if_addr = '0; lsb_en = 1'b0; lsb_addr = '0;
      lsb_type = '0; lsb_wdata = '0; mc_done = 1'b0; mc_rdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({if_rdy, lsb_rdy, mc_req, mc_wr, mc_len, mc_addr, mc_wdata, if_data, lsb_rdata} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got req=%b wr=%b len=%0d addr=%h, required all zero",
                  mc_req, mc_wr, mc_len, mc_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (mc_req !== 1'b0) begin fails++; $display("FAIL idle_after_reset: mc_req=%b required 0", mc_req); end
   endtask

   task automatic test_fetch();
      if_en = 1'b1; if_addr = 32'h100;
      @(negedge clk);
      checks++;
      if ({mc_req, mc_wr, mc_len, mc_addr} !== {1'b1, 1'b0, 3'd4, 32'h100}) begin
         fails++;
         $display("FAIL fetch_issue: req=%b wr=%b len=%0d addr=%h required 1 0 4 00000100",
                  mc_req, mc_wr, mc_len, mc_addr);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (mc_req !== 1'b1 || if_rdy !== 1'b0) begin
         fails++; $display("FAIL fetch_wait: req=%b rdy=%b required 1 0", mc_req, if_rdy);
      end
      mc_done = 1'b1; mc_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mc_done = 1'b0; mc_rdata = '0;
      checks++;
      if (if_rdy !== 1'b1 || if_data !== 32'hDEAD_BEEF) begin
         fails++; $display("FAIL fetch_data: rdy=%b data=%h required 1 deadbeef", if_rdy, if_data);
      end
      checks++;
      if (mc_req !== 1'b0) begin fails++; $display("FAIL fetch_req_drop: mc_req=%b required 0", mc_req); end
      if_en = 1'b0;
      @(negedge clk);
      checks++;
      if (if_rdy !== 1'b0 || mc_req !== 1'b0) begin
         fails++; $display("FAIL fetch_pulse: rdy=%b req=%b required 0 0", if_rdy, mc_req);
      end
   endtask

   task automatic test_lsb_types();
      logic [2:0]  ty  [8];
      logic [31:0] rd  [8];
      logic [31:0] exp [8];
      logic [2:0]  len [8];
      logic        wr  [8];
      logic        seen, wr_s;
      logic [31:0] a_s;
      logic [2:0]  l_s;
      ty  = '{LSB_LB, LSB_LBU, LSB_LH, LSB_LHU, LSB_LW, LSB_SB, LSB_SH, LSB_SW};
      rd  = '{32'h80, 32'h80, 32'h8001, 32'h8001, 32'h1234_5678, 32'hFF, 32'hFF, 32'hFF};
      exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h1234_5678, 32'h0, 32'h0, 32'h0};
      len = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4};
      wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         lsb_en = 1'b1; lsb_type = ty[i]; lsb_addr = 32'h20 + 32'(i * 4);
         lsb_wdata = 32'hA0 + 32'(i);
         @(negedge clk);
         checks++;
         if (mc_wdata !== 32'hA0 + 32'(i)) begin
            fails++; $display("FAIL lsb_wdata[%0d]: got %h required %h", i, mc_wdata, 32'hA0 + 32'(i));
         end
         mc_serve(2, rd[i], seen, a_s, l_s, wr_s);
         checks++;
         if (!seen || a_s !== 32'h20 + 32'(i * 4) || l_s !== len[i] || wr_s !== wr[i]) begin
            fails++;
            $display("FAIL lsb_cmd[%0d]: seen=%b addr=%h len=%0d wr=%b required len=%0d wr=%b",
                     i, seen, a_s, l_s, wr_s, len[i], wr[i]);
         end
         checks++;
         if (lsb_rdy !== 1'b1 || lsb_rdata !== exp[i]) begin
            fails++;
            $display("FAIL lsb_rdata[%0d]: rdy=%b data=%h required 1 %h", i, lsb_rdy, lsb_rdata, exp[i]);
         end
         lsb_en = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] order [6];
      logic        seen, wr_s;
      logic [31:0] a_s;
      logic [2:0]  l_s;
      order = '{32'h2000, 32'h2000, 32'h1000, 32'h2000, 32'h2000, 32'h1000};
      if_en = 1'b1; if_addr = 32'h1000;
      lsb_en = 1'b1; lsb_addr = 32'h2000; lsb_type = LSB_LW;
      for (int i = 0; i < 6; i++) begin
         mc_serve(1, 32'h0, seen, a_s, l_s, wr_s);
         checks++;
         if (!seen || a_s !== order[i]) begin
            fails++; $display("FAIL grant_order[%0d]: seen=%b addr=%h required %h", i, seen, a_s, order[i]);
         end
         @(negedge clk);
         checks++;
         if (mc_req !== 1'b0) begin
            fails++; $display("FAIL idle_gap[%0d]: mc_req=%b required 0", i, mc_req);
         end
      end
      if_en = 1'b0; lsb_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_flush();
      logic        seen, wr_s;
      logic [31:0] a_s;
      logic [2:0]  l_s;
      // Flush in IDLE hides the fetch for one cycle.
      if_en = 1'b1; if_addr = 32'h300; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (mc_req !== 1'b0) begin fails++; $display("FAIL flush_idle: mc_req=%b required 0", mc_req); end
      @(negedge clk);
      checks++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h300) begin
         fails++; $display("FAIL flush_idle_regrant: req=%b addr=%h required 1 00000300", mc_req, mc_addr);
      end
      // Flush two cycles into the fetch, LSB waiting behind it.
      @(negedge clk);
      flush = 1'b1; if_en = 1'b0;
      lsb_en = 1'b1; lsb_type = LSB_LW; lsb_addr = 32'h400;
      @(negedge clk);
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (mc_req !== 1'b1 || if_rdy !== 1'b0 || mc_addr !== 32'h300) begin
            fails++; $display("FAIL drain_hold[%0d]: req=%b rdy=%b addr=%h required 1 0 00000300",
                              i, mc_req, if_rdy, mc_addr);
         end
         if (i == 0) @(negedge clk);
      end
      mc_done = 1'b1; mc_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      mc_done = 1'b0; mc_rdata = '0;
      checks++;
      if (mc_req !== 1'b0 || if_rdy !== 1'b0) begin
         fails++; $display("FAIL drain_end: req=%b rdy=%b required 0 0", mc_req, if_rdy);
      end
      mc_serve(1, 32'h55, seen, a_s, l_s, wr_s);
      checks++;
      if (!seen || a_s !== 32'h400 || lsb_rdy !== 1'b1 || lsb_rdata !== 32'h55) begin
         fails++; $display("FAIL post_flush_lsb: seen=%b addr=%h rdy=%b data=%h required 1 00000400 1 00000055",
                           seen, a_s, lsb_rdy, lsb_rdata);
      end
      lsb_en = 1'b0;
      @(negedge clk);
      // Flush coincident with mc_done.
      if_en = 1'b1; if_addr = 32'h500;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1; if_en = 1'b0; mc_done = 1'b1; mc_rdata = 32'h1234;
      @(negedge clk);
      flush = 1'b0; mc_done = 1'b0; mc_rdata = '0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (if_rdy !== 1'b0 || mc_req !== 1'b0) begin
            fails++; $display("FAIL flush_done[%0d]: rdy=%b req=%b required 0 0", i, if_rdy, mc_req);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_io_wait();
      logic        seen, wr_s;
      logic [31:0] a_s;
      logic [2:0]  l_s;
      io_buffer_full = 1'b1;
      lsb_en = 1'b1; lsb_type = LSB_SB; lsb_addr = 32'h0003_0000; lsb_wdata = 32'hA5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (mc_req !== 1'b0) begin fails++; $display("FAIL io_wait[%0d]: mc_req=%b required 0", i, mc_req); end
      end
      io_buffer_full = 1'b0;
      @(negedge clk);
      checks++;
      if ({mc_req, mc_wr, mc_len, mc_addr, mc_wdata} !== {1'b1, 1'b1, 3'd1, 32'h0003_0000, 32'hA5}) begin
         fails++; $display("FAIL io_issue: req=%b wr=%b len=%0d addr=%h wdata=%h required 1 1 1 00030000 000000a5",
                           mc_req, mc_wr, mc_len, mc_addr, mc_wdata);
      end
      mc_serve(1, 32'h0, seen, a_s, l_s, wr_s);
      checks++;
      if (!seen || lsb_rdy !== 1'b1 || lsb_rdata !== 32'h0) begin
         fails++; $display("FAIL io_done: seen=%b rdy=%b data=%h required 1 1 0", seen, lsb_rdy, lsb_rdata);
      end
      lsb_en = 1'b0;
      @(negedge clk);
      // Just below the IO window a full buffer must not stall the store.
      io_buffer_full = 1'b1;
      lsb_en = 1'b1; lsb_type = LSB_SW; lsb_addr = 32'h0002_FFFC;
      @(negedge clk);
      checks++;
      if (mc_req !== 1'b1) begin fails++; $display("FAIL below_io_base: mc_req=%b required 1", mc_req); end
      mc_serve(1, 32'h0, seen, a_s, l_s, wr_s);
      lsb_en = 1'b0; io_buffer_full = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_rdy_hold();
      if_en = 1'b1; if_addr = 32'h600;
      @(negedge clk);
      rdy_in = 1'b0; mc_done = 1'b1; mc_rdata = 32'h1111_1111;
      repeat (2) @(negedge clk);
      checks++;
      if (mc_req !== 1'b1 || if_rdy !== 1'b0) begin
         fails++; $display("FAIL rdy_freeze: req=%b rdy=%b required 1 0", mc_req, if_rdy);
      end
      rdy_in = 1'b1; mc_done = 1'b0; mc_rdata = '0;
      @(negedge clk);
      checks++;
      if (mc_req !== 1'b1) begin fails++; $display("FAIL rdy_resume: mc_req=%b required 1", mc_req); end
      mc_done = 1'b1; mc_rdata = 32'h600D;
      @(negedge clk);
      mc_done = 1'b0; mc_rdata = '0;
      checks++;
      if (if_rdy !== 1'b1 || if_data !== 32'h600D) begin
         fails++; $display("FAIL rdy_done: rdy=%b data=%h required 1 0000600d", if_rdy, if_data);
      end
      if_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic        seen, wr_s;
      logic [31:0] a_s;
      logic [2:0]  l_s;
      lsb_en = 1'b1; lsb_type = LSB_LW; lsb_addr = 32'h40;
      @(negedge clk);
      checks++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h40) begin
         fails++; $display("FAIL pre_reset: req=%b addr=%h required 1 00000040", mc_req, mc_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mc_req, mc_addr, mc_len, mc_wr, lsb_rdy} !== '0) begin
         fails++; $display("FAIL async_reset: req=%b addr=%h len=%0d required all zero", mc_req, mc_addr, mc_len);
      end
      lsb_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (mc_req !== 1'b0) begin fails++; $display("FAIL post_reset_idle: mc_req=%b required 0", mc_req); end
      if_en = 1'b1; if_addr = 32'h700;
      @(negedge clk);
      checks++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h700) begin
         fails++; $display("FAIL post_reset_grant: req=%b addr=%h required 1 00000700", mc_req, mc_addr);
      end
      mc_serve(1, 32'h7777, seen, a_s, l_s, wr_s);
      checks++;
      if (!seen || if_rdy !== 1'b1 || if_data !== 32'h7777) begin
         fails++; $display("FAIL post_reset_fetch: seen=%b rdy=%b data=%h required 1 1 00007777",
                           seen, if_rdy, if_data);
      end
      if_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_lsb_types();
      test_back_to_back();
      test_flush();
      test_io_wait();
      test_rdy_hold();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 2, consecutive LSB grants allowed while a fetch waits.
REQ-002 Parameter: IO_BASE, default 32'h0003_0000, lowest memory-mapped IO address.
REQ-003 Port: clk_in  input  1  system clock; one clock, all state on its rising edge.
REQ-004 Port: rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 Port: rdy_in  input  1  global enable; low freezes all state.
REQ-006 Port: flush  input  1  pipeline flush; squashes fetch traffic.
REQ-007 Port: io_buffer_full  input  1  IO output buffer full.
REQ-008 Ports: if_en in 1, if_addr in 32, if_rdy out 1, if_data out 32  instruction-fetch requester (always word).
REQ-009 Ports: lsb_en in 1, lsb_addr in 32, lsb_type in LSB_TYPE_WIDTH, lsb_wdata in 32, lsb_rdy out 1, lsb_rdata out 32  load/store requester.
REQ-010 Ports: mc_req out 1, mc_addr out 32, mc_wr out 1, mc_len out 3 (1/2/4 bytes), mc_wdata out 32, mc_done in 1, mc_rdata in 32 (zero-extended)  downstream port to the byte-serial memory controller.

Function
REQ-011 Requester handshake: en/addr/type/wdata held stable until rdy; rdy is a one-cycle pulse coincident with valid data.
REQ-012 Downstream handshake: mc_* held stable from mc_req rise until mc_done; mc_req drops the cycle after mc_done.
REQ-013 States: IDLE, BUSY_IF, BUSY_LSB, DRAIN, IO_WAIT.
REQ-014 IDLE, both requesting: LSB wins unless starve count equals STARVE_LIMIT, then fetch wins.
REQ-015 Starve count: increments per LSB grant while if_en is high, clears on any fetch grant or when if_en is low, saturates at STARVE_LIMIT.
REQ-016 Grant to issue: mc_req asserted the cycle after grant (registered); no combinational en-to-mc_req path.
REQ-017 BUSY_IF + mc_done: if_rdy=1, if_data=mc_rdata, return to IDLE.
REQ-018 BUSY_LSB + mc_done: lsb_rdy=1; LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW pass, stores drive lsb_rdata=0.
REQ-019 mc_len: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW and fetch; mc_wr=1 only for SB/SH/SW.
REQ-020 Store with lsb_addr>=IO_BASE while io_buffer_full: enter IO_WAIT, no mc_req; issue when io_buffer_full low.
REQ-021 flush in BUSY_IF: enter DRAIN, keep mc_req until mc_done, discard data, no if_rdy, then IDLE.
REQ-022 flush in IDLE: pending if_en ignored that cycle; LSB request still arbitrated normally.
REQ-023 flush never aborts BUSY_LSB or IO_WAIT; LSB accesses always complete.
REQ-024 flush on the same cycle as mc_done in BUSY_IF: data discarded, if_rdy stays 0, next state IDLE.
REQ-025 Back-to-back: new grant evaluated in the cycle after any rdy pulse; minimum one idle cycle between transactions.
REQ-026 rdy_in low: state, counters, outputs hold; mc_done ignored while rdy_in low.

Reset
REQ-027 rst_n_in low: state=IDLE, starve count=0, if_rdy=lsb_rdy=mc_req=mc_wr=0, all data/addr outputs 0, mc_len=0.
REQ-028 Reset mid-transaction abandons it; downstream controller is reset by the same signal.

Structure
REQ-029 LSB_TYPE_WIDTH and type encodings (LB,LH,LW,LBU,LHU,SB,SH,SW) live in the shared defines header, alongside IO_BASE default.
REQ-030 One sub-module natural: lsb_extend (combinational type-to-len/wr decode and load extension); arbiter FSM stays in mem_arbiter.

Verification
REQ-031 Fetch only, if_addr=0x100, mc_rdata=0xDEADBEEF after 4 cycles -> mc_len=4, mc_wr=0, if_rdy pulse with if_data=0xDEADBEEF.
REQ-032 LB at 0x20, mc_rdata=0x80 -> lsb_rdata=0xFFFFFF80; LBU same -> 0x00000080; LH 0x8001 -> 0xFFFF8001.
REQ-033 if_en and lsb_en held continuously, STARVE_LIMIT=2 -> grant order LSB,LSB,IF,LSB,LSB,IF.
REQ-034 flush 2 cycles into BUSY_IF -> mc_req held to mc_done, no if_rdy, next pending LSB granted afterwards.
REQ-035 SB to 0x30000 with io_buffer_full=1 for 5 cycles -> no mc_req for 5 cycles, then mc_wr=1, mc_len=1, lsb_rdy after mc_done.
REQ-036 rst_n_in low mid-BUSY_LSB, asynchronous to clk_in -> all outputs 0 immediately, state IDLE on release.
